fifo_generic: RTL and testbench

FIFO_GENERIC -- requirements
Module: fifo_generic

---
 rtl/fifo_generic.sv | 89 ++++++++
 tb/tb_fifo_generic.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_generic.sv
// Synchronous single-clock FIFO with any depth >= 2, registered read data and count-decoded flags.
// Optional simulation checks for dropped writes and ignored reads are enabled by defining FIFO_GENERIC_CHECK_EN.
module fifo_generic #(
  parameter int FIFO_DEPTH        = 8,
  parameter int FIFO_DATA_WIDTH   = 8,
  parameter int ALMOSTFULL_DEPTH  = 3,
  parameter int ALMOSTEMPTY_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       clk_enable,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [FIFO_DATA_WIDTH-1:0] write_data,
  output logic [FIFO_DATA_WIDTH-1:0] read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - ALMOSTFULL_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOSTEMPTY_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       rd_accept;
  logic                       wr_accept;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign rd_accept = read && !empty;
  assign wr_accept = write && (!full || rd_accept);

  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_empty = (count <= CNT_AE);
  assign almost_full  = (count >= CNT_AF);

  always_ff @(posedge clk) begin
    if (!reset && clk_enable && wr_accept) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      read_data <= '0;
    end else if (clk_enable) begin
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_accept) begin
        read_data <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_GENERIC_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset && clk_enable) begin
      if (write && !wr_accept) begin
        $error("fifo_generic: write dropped on full FIFO at time %0t", $time);
      end
      if (read && empty) begin
        $error("fifo_generic: read ignored on empty FIFO at time %0t", $time);
      end
    end
  end
`else
  // Checking disabled: no additional logic.
`endif

endmodule

// File: tb/tb_fifo_generic.sv
// Directed bench for fifo_generic: a queue scoreboard predicts read data and flags after every edge.
module tb_fifo_generic;

  localparam int DEPTH = 8;
  localparam int AE    = 3;
  localparam int AF    = 3;

  logic       clk;
  logic       clk_enable;
  logic       reset;
  logic       write;
  logic       read;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;

  logic [7:0] sb_q [$];
  logic [7:0] exp_rd;
  int         n_cmp;
  int         n_err;

  fifo_generic dut (
    .clk          (clk),
    .clk_enable   (clk_enable),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .write_data   (write_data),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("read_data",    32'(read_data),    32'(exp_rd));
    chk("empty",        32'(empty),        32'(sb_q.size() == 0));
    chk("full",         32'(full),         32'(sb_q.size() == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= AE));
    chk("almost_full",  32'(almost_full),  32'(sb_q.size() >= DEPTH - AF));
  endtask

  // Drive one edge, advance the scoreboard, then compare just after the edge.
  task automatic step(input logic rst, input logic en, input logic w, input logic r,
                      input logic [7:0] d);
    logic rd_acc;
    logic wr_acc;
    reset      = rst;
    clk_enable = en;
    write      = w;
    read       = r;
    write_data = d;
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      exp_rd = '0;
    end else if (en) begin
      rd_acc = r && (sb_q.size() != 0);
      wr_acc = w && ((sb_q.size() < DEPTH) || rd_acc);
      if (rd_acc) exp_rd = sb_q.pop_front();
      if (wr_acc) sb_q.push_back(d);
    end
    check_all();
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    exp_rd = '0;

    // Reset for two cycles, the second with clk_enable low and both requests active.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_ae",       32'(almost_empty), 32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_af",       32'(almost_full),  32'd0);
    chk("rst_rdata",    32'(read_data),    32'd0);

    // Ten writes, one every other cycle; the last two hit a full FIFO.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'(i - 1));
      if (i == 3) chk("ae_after_3", 32'(almost_empty), 32'd1);
      if (i == 4) chk("ae_after_4", 32'(almost_empty), 32'd0);
      if (i == 5) chk("af_after_5", 32'(almost_full),  32'd1);
      if (i >= 8) chk("full_after_8", 32'(full),      32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end

    // Ten reads: 0..7 come out, the last two are ignored and read_data holds 7.
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      chk("read_seq", 32'(read_data), (k <= 8) ? 32'(k - 1) : 32'd7);
      if (k >= 8) chk("empty_after_8", 32'(empty), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end

    // Simultaneous read and write on a full FIFO.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA0);
    chk("full_rw_out",  32'(read_data), 32'h10);
    chk("full_rw_full", 32'(full),      32'd1);

    // Drain to three entries, then read and write together.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA1);
    chk("three_rw_out", 32'(read_data), 32'h16);
    chk("three_rw_ae",  32'(almost_empty), 32'd1);
    chk("three_rw_emp", 32'(empty),        32'd0);
    while (sb_q.size() != 0) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("drain_last", 32'(read_data), 32'hA1);

    // Clock enable low freezes everything even with both requests active.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h66);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
    chk("ce_hold_rdata", 32'(read_data), 32'hA1);

    // Reset with data present discards it.
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h88);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("rst_mid_rdata", 32'(read_data), 32'd0);

    // Twenty writes interleaved with reads, crossing the pointer wrap several times.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, (i % 3) != 0, 8'(8'hC0 + i));
    end
    while (sb_q.size() != 0) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("wrap_last", 32'(read_data), 32'hD3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
